// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the multiplexer select sequencer.
//   NUM_CH     : number of multiplexer channels scanned
//   SEL_W      : width of the select bus
//   db_state_e : key debouncer state encoding
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    DbIdle,
    DbPressWait,
    DbPressed,
    DbReleaseWait
  } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debouncer for an active-low push key.
//   clk    : system clock
//   reset  : synchronous reset, active-high
//   step_n : raw key, active-low, asynchronous to clk
//   press  : registered one-cycle pulse per accepted press
module key_debounce
  import mux_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic step_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // One extra bit so the incremented count can be compared against the limit itself.
  localparam logic [CntW:0] CntLimit = (CntW + 1)'(DEBOUNCE_CYCLES);

  logic [1:0]      sync_d, sync_q;
  db_state_e       state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            press_d, press_q;
  logic [CntW:0]   cnt_inc;
  logic            hit;
  logic            key_hi;

  assign key_hi  = sync_q[1];
  assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
  // The sample being taken now would be the DEBOUNCE_CYCLES-th stable one.
  assign hit     = (cnt_inc == CntLimit);

  always_comb begin
    sync_d  = {sync_q[0], step_n};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      DbIdle: begin
        if (!key_hi) begin
          if (hit) begin
            state_d = DbPressed;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            state_d = DbPressWait;
            cnt_d   = cnt_inc[CntW-1:0];
          end
        end
      end
      DbPressWait: begin
        if (key_hi) begin
          state_d = DbIdle;
          cnt_d   = '0;
        end else if (hit) begin
          state_d = DbPressed;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc[CntW-1:0];
        end
      end
      DbPressed: begin
        if (key_hi) begin
          if (hit) begin
            state_d = DbIdle;
            cnt_d   = '0;
          end else begin
            state_d = DbReleaseWait;
            cnt_d   = cnt_inc[CntW-1:0];
          end
        end
      end
      DbReleaseWait: begin
        if (!key_hi) begin
          state_d = DbPressed;
          cnt_d   = '0;
        end else if (hit) begin
          state_d = DbIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CntW-1:0];
        end
      end
      default: begin
        state_d = DbIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= DbIdle;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mux_scan_seq.sv
// Select sequencer for a 4:1 switch multiplexer. Steps sel 0->1->2->3->0 on a
// debounced key press (auto_en=0) or a prescaled scan tick (auto_en=1), and
// latches the returned mux bit into a per-channel capture register.
//   clk, reset   : clock and synchronous active-high reset
//   step_n       : raw active-low key
//   auto_en      : 1 = automatic scan, 0 = manual stepping
//   mux_in       : bit returned by the multiplexer for the current sel
//   sel          : multiplexer select
//   capture      : last sampled value per channel
//   sample_valid : pulse, capture updated at this edge
//   wrap         : pulse, sel went 3 -> 0 at this edge
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_n,
  input  logic              auto_en,
  input  logic              mux_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] capture,
  output logic              sample_valid,
  output logic              wrap
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  logic [PreW-1:0]   presc_d, presc_q;
  logic [SEL_W-1:0]  sel_d, sel_q;
  logic [NUM_CH-1:0] capture_d, capture_q;
  logic              sv_d, sv_q;
  logic              wrap_d, wrap_q;
  logic              press;
  logic              tick;
  logic              adv;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .step_n(step_n),
    .press (press)
  );

  // Gated by auto_en so a TICK_DIV of 1 cannot tick while the prescaler is held.
  assign tick = auto_en && (presc_q == PreLast);
  assign adv  = auto_en ? tick : press;

  always_comb begin
    presc_d   = '0;
    sel_d     = sel_q;
    capture_d = capture_q;
    sv_d      = adv;
    wrap_d    = adv && (&sel_q);
    if (auto_en && !tick) begin
      presc_d = presc_q + PreW'(1);
    end
    if (adv) begin
      capture_d[sel_q] = mux_in;
      sel_d            = sel_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      sel_q     <= '0;
      capture_q <= '0;
      sv_q      <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      sel_q     <= sel_d;
      capture_q <= capture_d;
      sv_q      <= sv_d;
      wrap_q    <= wrap_d;
    end
  end

  assign sel          = sel_q;
  assign capture      = capture_q;
  assign sample_valid = sv_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Expected advances are pushed to a queue as stimulus is planned and popped
// whenever the DUT pulses sample_valid.
module tb_mux_scan_seq;

  logic       clk;
  logic       reset;
  logic       step_n;
  logic       auto_en;
  logic       mux_in;
  logic [1:0] sel;
  logic [3:0] capture;
  logic       sample_valid;
  logic       wrap;
  logic [3:0] data;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] cap;
    logic       wrap;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [1:0] exp_sel;
  logic [3:0] exp_cap;
  int         n_cmp;
  int         n_fail;
  int         sv_cnt;
  int         wrap_cnt;

  mux_scan_seq #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_n      (step_n),
    .auto_en     (auto_en),
    .mux_in      (mux_in),
    .sel         (sel),
    .capture     (capture),
    .sample_valid(sample_valid),
    .wrap        (wrap)
  );

  // Behavioural 4:1 multiplexer.
  assign mux_in = data[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one advance expected at relative cycle cyc, using current data.
  function automatic void push_adv(input int cyc);
    exp_t x;
    x.cyc            = cyc;
    x.wrap           = (exp_sel == 2'd3);
    exp_cap[exp_sel] = data[exp_sel];
    exp_sel          = exp_sel + 2'd1;
    x.sel            = exp_sel;
    x.cap            = exp_cap;
    q.push_back(x);
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    step_n  = 1'($urandom_range(0, 1));
    auto_en = 1'($urandom_range(0, 1));
    data    = 4'($urandom_range(0, 15));
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      n_cmp += 4;
      if (sel !== 2'd0) begin
        n_fail++; $display("FAIL reset_sel c%0d: got %0d, required 0", c, sel);
      end
      if (capture !== 4'b0000) begin
        n_fail++; $display("FAIL reset_capture c%0d: got %b, required 0000", c, capture);
      end
      if (sample_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_sv c%0d: got %b, required 0", c, sample_valid);
      end
      if (wrap !== 1'b0) begin
        n_fail++; $display("FAIL reset_wrap c%0d: got %b, required 0", c, wrap);
      end
      step_n  = 1'($urandom_range(0, 1));
      data    = 4'($urandom_range(0, 15));
    end
    reset   = 1'b0;
    auto_en = 1'b0;
    step_n  = 1'b1;
    data    = 4'b0000;
    exp_sel = 2'd0;
    exp_cap = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (sample_valid !== 1'b0 || sel !== 2'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle c%0d: got sv=%b sel=%0d, required sv=0 sel=0",
                 c, sample_valid, sel);
      end
    end
  endtask

  task automatic test_auto_scan();
    data     = 4'b1010;
    sv_cnt   = 0;
    wrap_cnt = 0;
    for (int k = 1; k <= 4; k++) push_adv(4 * k);
    for (int c = 1; c <= 16; c++) begin
      auto_en = 1'b1;
      @(posedge clk); #1;
      if (sample_valid) sv_cnt++;
      if (wrap) wrap_cnt++;
      if (sample_valid || wrap) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL auto_adv: unexpected pulse c%0d sv=%b wrap=%b, required none",
                   c, sample_valid, wrap);
        end else begin
          e = q.pop_front();
          if ({sample_valid, sel, capture, wrap} !== {1'b1, e.sel, e.cap, e.wrap} || c != e.cyc) begin
            n_fail++;
            $display("FAIL auto_adv: got c%0d sel=%0d cap=%b wrap=%b, required c%0d sel=%0d cap=%b wrap=%b",
                     c, sel, capture, wrap, e.cyc, e.sel, e.cap, e.wrap);
          end
        end
      end
    end
    n_cmp += 3;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL auto_missing: got %0d advances pending, required 0", q.size());
    end
    if (capture !== 4'b1010 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL auto_final: got cap=%b sel=%0d, required cap=1010 sel=0", capture, sel);
    end
    if (sv_cnt != 4 || wrap_cnt != 1) begin
      n_fail++;
      $display("FAIL auto_counts: got sv=%0d wrap=%0d, required sv=4 wrap=1", sv_cnt, wrap_cnt);
    end
    q.delete();
    auto_en = 1'b0;
  endtask

  task automatic test_clean_press();
    data = 4'b0101;
    push_adv(6);
    for (int c = 1; c <= 20; c++) begin
      step_n = (c <= 10) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (sample_valid || wrap) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL clean_adv: unexpected pulse c%0d sv=%b wrap=%b, required none",
                   c, sample_valid, wrap);
        end else begin
          e = q.pop_front();
          if ({sample_valid, sel, capture, wrap} !== {1'b1, e.sel, e.cap, e.wrap} || c != e.cyc) begin
            n_fail++;
            $display("FAIL clean_adv: got c%0d sel=%0d cap=%b wrap=%b, required c%0d sel=%0d cap=%b wrap=%b",
                     c, sel, capture, wrap, e.cyc, e.sel, e.cap, e.wrap);
          end
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL clean_missing: got %0d advances pending, required 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_bounce();
    data = 4'b0110;
    push_adv(16);
    for (int c = 1; c <= 26; c++) begin
      step_n = (c <= 2 || (c >= 4 && c <= 5) || (c >= 11 && c <= 16)) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (sample_valid || wrap) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bounce_adv: unexpected pulse c%0d sv=%b wrap=%b, required none",
                   c, sample_valid, wrap);
        end else begin
          e = q.pop_front();
          if ({sample_valid, sel, capture, wrap} !== {1'b1, e.sel, e.cap, e.wrap} || c != e.cyc) begin
            n_fail++;
            $display("FAIL bounce_adv: got c%0d sel=%0d cap=%b wrap=%b, required c%0d sel=%0d cap=%b wrap=%b",
                     c, sel, capture, wrap, e.cyc, e.sel, e.cap, e.wrap);
          end
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL bounce_missing: got %0d advances pending, required 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_held_repress();
    data = 4'b1100;
    push_adv(6);
    push_adv(116);
    for (int c = 1; c <= 130; c++) begin
      step_n = (c <= 100 || (c > 110 && c <= 120)) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (sample_valid || wrap) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL held_adv: unexpected pulse c%0d sv=%b wrap=%b, required none",
                   c, sample_valid, wrap);
        end else begin
          e = q.pop_front();
          if ({sample_valid, sel, capture, wrap} !== {1'b1, e.sel, e.cap, e.wrap} || c != e.cyc) begin
            n_fail++;
            $display("FAIL held_adv: got c%0d sel=%0d cap=%b wrap=%b, required c%0d sel=%0d cap=%b wrap=%b",
                     c, sel, capture, wrap, e.cyc, e.sel, e.cap, e.wrap);
          end
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL held_missing: got %0d advances pending, required 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_reset_mid_scan();
    data = 4'b1111;
    push_adv(4);
    push_adv(8);
    // Reset lands on the edge where the third tick would have advanced.
    exp_sel = 2'd0;
    exp_cap = 4'b0000;
    push_adv(16);
    push_adv(20);
    for (int c = 1; c <= 20; c++) begin
      auto_en = 1'b1;
      reset   = (c == 12);
      @(posedge clk); #1;
      if (c == 12) begin
        n_cmp++;
        if ({sel, capture, sample_valid, wrap} !== 8'b0) begin
          n_fail++;
          $display("FAIL midscan_reset: got sel=%0d cap=%b sv=%b wrap=%b, required all 0",
                   sel, capture, sample_valid, wrap);
        end
      end
      if (sample_valid || wrap) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL midscan_adv: unexpected pulse c%0d sv=%b wrap=%b, required none",
                   c, sample_valid, wrap);
        end else begin
          e = q.pop_front();
          if ({sample_valid, sel, capture, wrap} !== {1'b1, e.sel, e.cap, e.wrap} || c != e.cyc) begin
            n_fail++;
            $display("FAIL midscan_adv: got c%0d sel=%0d cap=%b wrap=%b, required c%0d sel=%0d cap=%b wrap=%b",
                     c, sel, capture, wrap, e.cyc, e.sel, e.cap, e.wrap);
          end
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL midscan_missing: got %0d advances pending, required 0", q.size());
    end
    q.delete();
    reset   = 1'b0;
    auto_en = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    exp_sel = 2'd0;
    exp_cap = 4'b0000;
    test_reset();
    test_auto_scan();
    test_clean_press();
    test_bounce();
    test_held_repress();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
